// File: rtl/mem_responder.sv
// mem_responder
// -------------
// Behavioural single-port data memory for a simple RV32I core. One request
// is accepted at a time, held for a fixed number of wait cycles, then
// answered with a single-cycle response strobe. Byte/halfword/word loads
// and stores are supported, with sign or zero extension on loads and
// error reporting for misaligned, out-of-range and illegal-size accesses.
//
// Handshake: a request transfers at a rising edge where req_valid and
// req_ready are both 1. req_ready is 1 only while idle. The response
// (rsp_valid) is a one-cycle strobe with no backpressure; rsp_rdata and
// rsp_err are qualified by rsp_valid and hold their values between responses.
//
// Parameters
//   DEPTH_WORDS : memory size in 32-bit words (power of two, >= 4)
//   LATENCY     : extra wait cycles per access (0..15)
//
// Ports
//   clk        in   sole clock, rising edge
//   rst        in   synchronous active-high reset (memory contents kept)
//   req_valid  in   request present
//   req_we     in   1 = store, 0 = load
//   req_addr   in   byte address
//   req_wdata  in   store data, right-aligned
//   req_size   in   RV32I funct3 (000 b, 001 h, 010 w, 100 bu, 101 hu)
//   req_ready  out  request can be accepted (idle)
//   rsp_valid  out  one-cycle response strobe
//   rsp_rdata  out  load result (0 for stores and faults)
//   rsp_err    out  request faulted
module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW     = $clog2(DEPTH_WORDS);
  localparam logic [3:0] LAT_C  = LATENCY[3:0];

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q,   cnt_d;
  logic        we_q,    we_d;
  logic [31:0] addr_q,  addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  size_q,  size_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;

  logic [31:0] mem [DEPTH_WORDS];

  // Access decode, all from the latched request fields.
  logic [AW-1:0] word_idx;
  logic [31:0]   rd_word;
  logic          out_of_range;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic          acc_err;
  logic [3:0]    be;
  logic [31:0]   wlanes;
  logic [31:0]   load_val;
  logic          access_now;

  assign word_idx     = addr_q[AW+1:2];
  assign rd_word      = mem[word_idx];
  // Any address bit at or above the memory's byte span means out of range.
  assign out_of_range = (addr_q >> (AW + 2)) != 32'd0;
  assign half_v       = addr_q[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    byte_v = rd_word[7:0];
    case (addr_q[1:0])
      2'd0:    byte_v = rd_word[7:0];
      2'd1:    byte_v = rd_word[15:8];
      2'd2:    byte_v = rd_word[23:16];
      default: byte_v = rd_word[31:24];
    endcase
  end

  always_comb begin
    acc_err  = out_of_range;
    be       = 4'b0000;
    wlanes   = wdata_q;
    load_val = rd_word;
    case (size_q)
      3'b000: begin
        be       = 4'b0001 << addr_q[1:0];
        wlanes   = {4{wdata_q[7:0]}};
        load_val = {{24{byte_v[7]}}, byte_v};
      end
      3'b001: begin
        acc_err  = out_of_range | addr_q[0];
        be       = addr_q[1] ? 4'b1100 : 4'b0011;
        wlanes   = {2{wdata_q[15:0]}};
        load_val = {{16{half_v[15]}}, half_v};
      end
      3'b010: begin
        acc_err  = out_of_range | (addr_q[1:0] != 2'b00);
        be       = 4'b1111;
      end
      3'b100: begin
        // Unsigned sizes have no store form.
        acc_err  = out_of_range | we_q;
        load_val = {24'h0, byte_v};
      end
      3'b101: begin
        acc_err  = out_of_range | we_q | addr_q[0];
        load_val = {16'h0, half_v};
      end
      default: acc_err = 1'b1;
    endcase
  end

  // The WAIT->RESP edge is where the access happens.
  assign access_now = (state_q == S_WAIT) && (cnt_q == LAT_C);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    size_d  = size_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          size_d  = req_size;
          cnt_d   = 4'd0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (access_now) begin
          state_d = S_RESP;
          err_d   = acc_err;
          rdata_d = (acc_err || we_q) ? 32'h0 : load_val;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      size_q  <= 3'b000;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      size_q  <= size_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Storage is never reset; a reset on the access edge cancels the write.
  always_ff @(posedge clk) begin
    if (!rst && access_now && we_q && !acc_err) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[word_idx][8*i +: 8] <= wlanes[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning memory size in 32-bit words (power of two, at least 4).
REQ-002 SHALL have parameter LATENCY, default 2, meaning extra wait cycles per access (0..15).
REQ-003 SHALL have port clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port req_valid  in  1  core presents a memory request.
REQ-006 SHALL have port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL have port req_addr  in  32  byte address.
REQ-008 SHALL have port req_wdata  in  32  store data, right-aligned.
REQ-009 SHALL have port req_size  in  3  RV32I funct3: 000 b, 001 h, 010 w, 100 bu, 101 hu.
REQ-010 SHALL have port req_ready  out  1  responder can accept a request.
REQ-011 SHALL have port rsp_valid  out  1  one-cycle response strobe.
REQ-012 SHALL have port rsp_rdata  out  32  load result, extended per req_size.
REQ-013 SHALL have port rsp_err  out  1  request faulted; qualified by rsp_valid.

Function
REQ-014 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-015 SHALL accept a request at an edge where req_valid & req_ready; latch we/addr/wdata/size, clear counter, go to WAIT.
REQ-016 In WAIT, SHALL go to RESP at the edge where counter == LATENCY, else increment counter; WAIT lasts LATENCY+1 cycles.
REQ-017 SHALL perform the memory access (read sample and any write) at the WAIT->RESP edge, registering rsp_rdata/rsp_err at that edge.
REQ-018 SHALL hold rsp_valid = 1 in RESP for exactly one cycle, then return to IDLE unconditionally (no response backpressure).
REQ-019 Timing: accept at edge E0 -> rsp_valid high between edges E0+LATENCY+1 and E0+LATENCY+2; next accept no earlier than edge E0+LATENCY+3.
REQ-020 Memory SHALL be little-endian, word index = req_addr[log2(DEPTH_WORDS)+1:2].
REQ-021 Stores: size 000 writes only byte lane addr[1:0] with wdata[7:0]; 001 writes halfword lane addr[1] with wdata[15:0]; 010 writes all 4 bytes; untouched lanes unchanged.
REQ-022 Loads: 000/100 select byte addr[1:0], sign/zero-extend; 001/101 select halfword addr[1], sign/zero-extend; 010 full word.
REQ-023 Error (rsp_err = 1, rsp_rdata = 0, no write) on: halfword with addr[0]=1; word with addr[1:0]!=0; addr >= 4*DEPTH_WORDS; size 011/110/111; store with size 100/101.
REQ-024 rsp_rdata SHALL be 0 for stores and SHALL hold its value between responses.
REQ-025 req_valid changes while not in IDLE SHALL be ignored; latched request fields SHALL not change until return to IDLE.

Reset
REQ-026 At a rising edge with rst = 1: state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0; req_ready = 1 in the following cycle.
REQ-027 rst at the WAIT->RESP edge SHALL suppress the write and response; rst during RESP drops rsp_valid next cycle with the write already committed.
REQ-028 Memory contents SHALL NOT be cleared by reset.

Verification
REQ-029 LATENCY=2, accept sw 0x10/0xDEADBEEF at edge 0 -> rsp_valid only in cycle after edge 3, err 0; then lw 0x10 -> rdata 0xDEADBEEF.
REQ-030 Next, sb 0x11 data 0x80 -> lb 0x11 = 0xFFFFFF80, lbu 0x11 = 0x00000080, lw 0x10 = 0xDEAD80EF.
REQ-031 sh 0x12 data 0x1234 -> lw 0x10 = 0x123480EF; lh 0x13 -> err 1, rdata 0; sw 0x400 (DEPTH 256) -> err 1, lw 0x0 unchanged.
REQ-032 sw 0x20/0xCAFEF00D with rst pulsed during WAIT -> no rsp_valid, lw 0x20 returns prior value, req_ready 1 cycle after reset edge.
REQ-033 req_valid held high continuously with LATENCY=2 -> exactly one accept every 5 cycles, rsp_valid one cycle each.
REQ-034 LATENCY=0: accept at edge 0 -> rsp_valid in cycle after edge 1; back-to-back accepts every 3 cycles.
